// File: rtl/q_text_data.sv
// Query-text capture buffer: loads an ASCII stream (optionally upper-cased and
// space-collapsed), then replays it byte-by-byte and raises sdone at the end.
module q_text_data #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datain,
    input  logic       qen,
    input  logic       fen,
    input  logic       ken,
    input  logic       wr,
    output logic [7:0] qout,
    output logic       sdone
);

    typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   rd_ptr;
    logic          last_space;

    logic          wr_en, fresh, rd_first, rd_step, fin;
    logic [AW-1:0] base_ptr;
    logic [AW:0]   base_cnt;
    logic          base_ls;
    logic [7:0]    norm;
    logic          is_sp, drop, full, store;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Priority inside a state: wr beats ken; qen=0 freezes everything.
    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        fresh    = 1'b0;
        rd_first = 1'b0;
        rd_step  = 1'b0;
        fin      = 1'b0;
        if (qen) begin
            case (state)
                IDLE: if (wr) begin
                    state_n = LOAD;
                    wr_en   = 1'b1;
                    fresh   = 1'b1;
                end
                LOAD: if (wr) begin
                    wr_en = 1'b1;
                end else if (ken) begin
                    if (count != '0) begin
                        rd_first = 1'b1;
                        state_n  = READ;
                    end else begin
                        fin     = 1'b1;
                        state_n = DONE;
                    end
                end
                READ: if (wr) begin
                    state_n = LOAD;
                    wr_en   = 1'b1;
                    fresh   = 1'b1;
                end else if (ken) begin
                    if (rd_ptr < count) begin
                        rd_step = 1'b1;
                    end else begin
                        fin     = 1'b1;
                        state_n = DONE;
                    end
                end
                DONE: if (wr) begin
                    state_n = LOAD;
                    wr_en   = 1'b1;
                    fresh   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A restarting edge writes its byte into an empty buffer, so the write
    // path works from the post-clear pointers rather than the current ones.
    always_comb begin
        base_ptr = fresh ? '0 : wr_ptr;
        base_cnt = fresh ? '0 : count;
        base_ls  = fresh ? 1'b1 : last_space;
        norm     = datain;
        if (fen && datain >= 8'h61 && datain <= 8'h7A)
            norm = datain - 8'h20;
        is_sp = (norm == 8'h20);
        drop  = fen && is_sp && base_ls;
        full  = (base_cnt == (AW+1)'(DEPTH));
        store = !full && !drop;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && store)
            mem[base_ptr] <= norm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            last_space <= 1'b1;
            qout       <= 8'h00;
            sdone      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= base_ptr + AW'(store);
                count      <= base_cnt + (AW+1)'(store);
                last_space <= full ? base_ls : is_sp;
                if (fresh) begin
                    rd_ptr <= '0;
                    sdone  <= 1'b0;
                end
            end
            if (rd_first) begin
                qout   <= mem[0];
                rd_ptr <= (AW+1)'(1);
            end
            if (rd_step) begin
                qout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (fin)
                sdone <= 1'b1;
        end
    end

endmodule

// File: tb/tb_q_text_data.sv
// Scoreboard bench for q_text_data: load tasks push the expected replay bytes,
// playback pops and compares them edge by edge.
module tb_q_text_data;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst, qen, fen, ken, wr;
    logic [7:0] datain, qout;
    logic       sdone;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic       m_ls;
    logic [7:0] last_exp;

    always #5 clk = ~clk;

    q_text_data #(.DEPTH(DEPTH), .AW(5)) dut (
        .clk(clk), .rst(rst), .datain(datain), .qen(qen), .fen(fen),
        .ken(ken), .wr(wr), .qout(qout), .sdone(sdone)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic f);
        logic [7:0] c;
        c = d;
        if (f && c >= "a" && c <= "z") c = c - 8'd32;
        qen = 1'b1; wr = 1'b1; ken = 1'b0; fen = f; datain = d;
        if (exp_q.size() < DEPTH) begin
            if (!(f && c == 8'h20 && m_ls)) exp_q.push_back(c);
            m_ls = (c == 8'h20);
        end
        tick();
    endtask

    task automatic load_str(input string s, input logic f, input logic lead_sp, input logic trail_sp);
        exp_q.delete();
        m_ls = 1'b1;
        if (lead_sp) load_byte(8'h20, f);
        for (int i = 0; i < s.len(); i++) load_byte(s[i], f);
        if (trail_sp) load_byte(8'h20, f);
    endtask

    // Replays the buffer; optionally drops ken or qen for 3 edges after
    // the given character index.
    task automatic drain(input string tag, input int pause_at, input int freeze_at);
        int n, i;
        n = exp_q.size();
        i = 0;
        wr = 1'b0; ken = 1'b1; qen = 1'b1;
        while (exp_q.size() > 0) begin
            tick();
            last_exp = exp_q.pop_front();
            vectors++;
            if (qout !== last_exp || sdone !== 1'b0) begin
                miscompares++;
                $display("FAIL %s char %0d: qout=%h sdone=%b, want qout=%h sdone=0", tag, i, qout, sdone, last_exp);
            end
            if (i == pause_at) begin
                ken = 1'b0;
                repeat (3) begin
                    tick();
                    vectors++;
                    if (qout !== last_exp || sdone !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s pause: qout=%h sdone=%b, want %h 0", tag, qout, sdone, last_exp);
                    end
                end
                ken = 1'b1;
            end
            if (i == freeze_at) begin
                qen = 1'b0; wr = 1'b1; datain = 8'h41;
                repeat (3) begin
                    tick();
                    vectors++;
                    if (qout !== last_exp || sdone !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s freeze: qout=%h sdone=%b, want %h 0", tag, qout, sdone, last_exp);
                    end
                end
                qen = 1'b1; wr = 1'b0;
            end
            i++;
        end
        tick();
        vectors++;
        if (sdone !== 1'b1 || (n > 0 && qout !== last_exp)) begin
            miscompares++;
            $display("FAIL %s done: sdone=%b qout=%h, want sdone=1 qout=%h (n=%0d)", tag, sdone, qout, last_exp, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; qen = 1'b0; fen = 1'b0; ken = 1'b0; wr = 1'b0; datain = 8'h00;
        repeat (2) tick();
        vectors++;
        if (qout !== 8'h00 || sdone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: qout=%h sdone=%b, want 00 0", qout, sdone);
        end
        rst = 1'b0;
    endtask

    task automatic test_normalised();
        load_str("Which OS is present in S6 ", 1'b1, 1'b1, 1'b1);
        vectors++;
        if (exp_q.size() != 26) begin
            miscompares++;
            $display("FAIL norm_model_len: got %0d, want 26", exp_q.size());
        end
        drain("norm", 5, 12);
    endtask

    task automatic test_raw();
        load_str("Which OS is present in S6 ", 1'b0, 1'b1, 1'b1);
        drain("raw", -1, -1);
    endtask

    task automatic test_reset_mid_load();
        load_str("garbage", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if (qout !== 8'h00 || sdone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_load: qout=%h sdone=%b, want 00 0", qout, sdone);
        end
        rst = 1'b0;
        load_str("xyz", 1'b0, 1'b0, 1'b0);
        drain("post_reset", -1, -1);
    endtask

    task automatic test_overflow();
        exp_q.delete();
        m_ls = 1'b1;
        for (int i = 0; i < 40; i++) load_byte(8'(8'h30 + i), 1'b0);
        drain("overflow", -1, -1);
    endtask

    task automatic test_empty_restart();
        load_str("", 1'b1, 1'b1, 1'b0);
        drain("empty", -1, -1);
        load_byte(8'h6F, 1'b0);
        vectors++;
        if (sdone !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_sdone: sdone=%b, want 0", sdone);
        end
        exp_q.delete();
        exp_q.push_back(8'h6F);
        load_byte(8'h6B, 1'b0);
        exp_q.delete();
        exp_q.push_back(8'h6F);
        exp_q.push_back(8'h6B);
        drain("restart", -1, -1);
    endtask

    task automatic test_back_to_back();
        // wr during playback aborts and starts a fresh buffer with that byte.
        load_str("abcdef", 1'b1, 1'b0, 1'b0);
        wr = 1'b0; ken = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        m_ls = 1'b1;
        load_byte(8'h71, 1'b1);
        load_byte(8'h72, 1'b0);
        drain("abort", -1, -1);
    endtask

    initial begin
        test_reset();
        test_normalised();
        test_reset_mid_load();
        test_raw();
        test_overflow();
        test_empty_restart();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/q_text_data.md
Name: q_text_data

Overview:
- Query-text capture buffer for the speech/NLP front end.
- Loads an ASCII character stream (the spoken query as text) one byte per clock, optionally normalising it on the way in.
- Replays the stored text byte-by-byte to the downstream keyword stage.
- Flags completion with sdone.

Parameters:
DEPTH, 32, buffer capacity in characters (power of two)
AW, 5, address/count width, log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
datain  input  8  ASCII character in, sampled on rising clk
qen  input  1  query enable; when 0 the block freezes (no state, pointer or output change)
fen  input  1  filter enable; applies normalisation during load
ken  input  1  keyword-read enable; requests playback
wr  input  1  1 = load phase, 0 = read phase
qout  output  8  registered character out
sdone  output  1  playback complete; level, held until next load or reset

Behaviour:
- Reset (rst=1 at clk edge), which overrides everything:
  - state=IDLE, wr_ptr=0, count=0, rd_ptr=0, qout=8'h00, sdone=0, last_space=1.
  - Memory contents need not be cleared.
- Freeze: with qen=0, the edge does nothing apart from reset.
- States: IDLE, LOAD, READ, DONE.
- IDLE:
  - qen&wr -> LOAD; this same edge is treated as a LOAD write edge.
  - Otherwise stay.
- LOAD, write edge (qen&wr):
  - Normalise datain: if fen=1, bytes 8'h61-8'h7A have 8'h20 subtracted (upper-casing). Other bytes are unchanged.
  - Space filter when fen=1: drop byte 8'h20 if last_space=1 (collapses runs of spaces and drops leading spaces).
  - last_space = (stored/dropped byte == 8'h20).
  - Store accepted byte at mem[wr_ptr]; wr_ptr++, count++.
  - With fen=0, every byte is stored unchanged.
  - Full (count==DEPTH): further bytes are discarded silently; count saturates at DEPTH.
- LOAD with wr=0:
  - ken=0: hold, waiting.
  - ken=1 and count>0: qout<=mem[0], rd_ptr<=1, -> READ.
  - ken=1 and count=0: sdone<=1, -> DONE.
- READ:
  - Each edge with ken=1 and rd_ptr<count: qout<=mem[rd_ptr], rd_ptr++.
  - Edge with ken=1 and rd_ptr==count: sdone<=1, -> DONE; qout keeps the last character.
  - ken=0 pauses playback; qout holds.
  - wr=1 in READ aborts playback: -> LOAD with fresh buffer (count=0, pointers 0, last_space=1, sdone=0). That edge's byte is written.
- DONE:
  - sdone=1 and qout are held.
  - qen&wr restarts: -> LOAD with fresh buffer as above, sdone<=0 on that edge, byte written.
- Latency:
  - First character appears on qout one edge after the read condition is sampled.
  - Then one character per clock.
  - sdone asserts one edge after the final character.
  - Total of count+1 read edges.
- Simultaneous events:
  - rst beats everything, then qen=0 freeze, then wr=1, then ken.

Test Plan:
- Reset: rst=1 for 2 edges mid-LOAD -> qout=8'h00, sdone=0, count=0; next load starts at mem[0].
- Normalised load/playback:
  - qen=fen=1, wr=1; stream 8'h20 then "Which OS is present in S6 " with a trailing extra 8'h20, one per clk.
  - Then wr=0, ken=1.
  - -> qout sequence "WHICH OS IS PRESENT IN S6 " (26 bytes: 57 48 49 43 48 20 4F 53 20 ...). Leading space and duplicate trailing space are dropped.
  - sdone=1 on the 27th read edge.
- Raw load: fen=0, same stream -> all accepted bytes replayed unchanged, including lowercase 8'h68 and repeated 8'h20s.
- Pause/freeze:
  - Drop ken for 3 clocks mid-playback -> qout holds, no skipped characters.
  - qen=0 for 3 clocks -> no change at all.
- Overflow: load 40 bytes with fen=0 into DEPTH=32 -> exactly first 32 replayed, then sdone.
- Empty/restart:
  - wr=0, ken=1 with count=0 -> sdone=1 after 1 edge.
  - Then wr=1 from DONE -> sdone clears and a new load begins.
